reg_file_sb: RTL and testbench

- Parametrised successor to the datapath's two-read/one-write register file.
- Adds:
  - a clock and an asynchronous reset
  - a write enable
  - a hardwired zero register (optional)
  - write-to-read bypass
  - a per-register pending scoreboard, which marks destination registers of in-flight multi-cycle producers (loads, mult/div) so decode can stall on a RAW hazard.
- Sits between decode and execute in the MIPS datapath.

---
 rtl/reg_file_sb_if.sv | 29 ++
 rtl/reg_file_sb.sv | 91 +++++++++
 tb/tb_reg_file_sb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two read ports with busy flags, one write port,
// and the pending-set port with its count.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              busy1;
  logic              busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pend_set, pend_addr,
    input  rd_data1, rd_data2, busy1, busy2, pend_cnt
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pend_set, pend_addr,
    output rd_data1, rd_data2, busy1, busy2, pend_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// 2R/1W register file with optional hardwired r0, write-to-read bypass and a
// per-register pending scoreboard that lets decode stall on RAW hazards.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]             pend_q;
  logic [DEPTH-1:0]             pend_d;
  logic [ADDR_W:0]              cnt_q;
  logic [ADDR_W:0]              cnt_d;

  logic wr_ok_s;
  logic set_ok_s;
  logic inc_s;
  logic dec_s;
  logic zero1_s;
  logic zero2_s;
  logic hit1_s;
  logic hit2_s;

  // Qualify write/set strobes and derive the scoreboard next state.
  always_comb begin
    wr_ok_s  = bus.wr_en    && !(ZERO_REG && (bus.wr_addr   == '0));
    set_ok_s = bus.pend_set && !(ZERO_REG && (bus.pend_addr == '0));
    pend_d   = pend_q;
    if (wr_ok_s) begin
      pend_d[bus.wr_addr] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    // Set is applied after the clear so a same-address set wins.
    if (set_ok_s) begin
      pend_d[bus.pend_addr] = 1'b1;
    end else begin
      pend_d = pend_d;
    end
    inc_s = set_ok_s && !pend_q[bus.pend_addr];
    dec_s = wr_ok_s && pend_q[bus.wr_addr] &&
            !(set_ok_s && (bus.pend_addr == bus.wr_addr));
    cnt_d = cnt_q + (ADDR_W+1)'(inc_s) - (ADDR_W+1)'(dec_s);
  end

  // Array, pending bits and count; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok_s) begin
        mem_q[bus.wr_addr] <= bus.wr_data;
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports: zero register, then bypass (suppressed during reset), then array.
  always_comb begin
    zero1_s = ZERO_REG && (bus.rd_addr1 == '0);
    zero2_s = ZERO_REG && (bus.rd_addr2 == '0);
    hit1_s  = BYPASS && bus.wr_en && (bus.wr_addr == bus.rd_addr1);
    hit2_s  = BYPASS && bus.wr_en && (bus.wr_addr == bus.rd_addr2);
    if (zero1_s) begin
      bus.rd_data1 = '0;
    end else if (hit1_s && !rst) begin
      bus.rd_data1 = bus.wr_data;
    end else begin
      bus.rd_data1 = mem_q[bus.rd_addr1];
    end
    if (zero2_s) begin
      bus.rd_data2 = '0;
    end else if (hit2_s && !rst) begin
      bus.rd_data2 = bus.wr_data;
    end else begin
      bus.rd_data2 = mem_q[bus.rd_addr2];
    end
    bus.busy1    = pend_q[bus.rd_addr1] && !hit1_s;
    bus.busy2    = pend_q[bus.rd_addr2] && !hit2_s;
    bus.pend_cnt = cnt_q;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized self-checking bench for reg_file_sb against an array-based model.
module tb_reg_file_sb;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [31:0] mem_m  [32];
  bit          pend_m [32];

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem_m[i]  = 32'd0;
      pend_m[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(pend_m[i]);
    return c;
  endfunction

  function automatic logic [31:0] model_rd(input int a, input bit we, input int wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && wa == a) return wd;
    return mem_m[a];
  endfunction

  function automatic bit model_busy(input int a, input bit we, input int wa);
    if (a == 0) return 1'b0;
    return pend_m[a] && !(we && wa == a);
  endfunction

  // One clock: apply inputs, check combinational outputs before the edge, update model.
  task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                       input bit ps, input int pa, input int ra1, input int ra2);
    bus.wr_en     = we;
    bus.wr_addr   = 5'(wa);
    bus.wr_data   = wd;
    bus.pend_set  = ps;
    bus.pend_addr = 5'(pa);
    bus.rd_addr1  = 5'(ra1);
    bus.rd_addr2  = 5'(ra2);
    #1;
    check_eq("rd_data1", 64'(bus.rd_data1), 64'(model_rd(ra1, we, wa, wd)));
    check_eq("rd_data2", 64'(bus.rd_data2), 64'(model_rd(ra2, we, wa, wd)));
    check_eq("busy1", 64'(bus.busy1), 64'(model_busy(ra1, we, wa)));
    check_eq("busy2", 64'(bus.busy2), 64'(model_busy(ra2, we, wa)));
    check_eq("pend_cnt", 64'(bus.pend_cnt), 64'(model_count()));
    @(posedge clk);
    if (we && wa != 0) begin
      mem_m[wa]  = wd;
      pend_m[wa] = 1'b0;
    end
    if (ps && pa != 0) pend_m[pa] = 1'b1;
    #1;
    check_eq("pend_cnt_post", 64'(bus.pend_cnt), 64'(model_count()));
  endtask

  // Pulse reset between edges and check the outputs clear before the next edge.
  task automatic async_reset(input int ra);
    bus.wr_en    = 1'b0;
    bus.pend_set = 1'b0;
    bus.rd_addr1 = 5'(ra);
    bus.rd_addr2 = 5'(ra);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_rd1", 64'(bus.rd_data1), 64'd0);
    check_eq("arst_rd2", 64'(bus.rd_data2), 64'd0);
    check_eq("arst_busy1", 64'(bus.busy1), 64'd0);
    check_eq("arst_cnt", 64'(bus.pend_cnt), 64'd0);
    #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 5'd0;
    bus.wr_data   = 32'd0;
    bus.pend_set  = 1'b0;
    bus.pend_addr = 5'd0;
    bus.rd_addr1  = 5'd2;
    bus.rd_addr2  = 5'd1;
    #3;
    check_eq("rst_rd1", 64'(bus.rd_data1), 64'd0);
    check_eq("rst_rd2", 64'(bus.rd_data2), 64'd0);
    check_eq("rst_busy1", 64'(bus.busy1), 64'd0);
    check_eq("rst_busy2", 64'(bus.busy2), 64'd0);
    check_eq("rst_cnt", 64'(bus.pend_cnt), 64'd0);

    // Write and set during reset must be discarded and not bypassed.
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd2;
    bus.wr_data   = 32'd77;
    bus.pend_set  = 1'b1;
    bus.pend_addr = 5'd2;
    #1;
    check_eq("rst_byp_rd1", 64'(bus.rd_data1), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 0, 32'd0, 1'b0, 0, 2, 2);

    drive(1'b1, 2, 32'd25, 1'b0, 0, 2, 1);
    drive(1'b0, 0, 32'd0, 1'b0, 0, 2, 2);
    drive(1'b1, 5, 32'd3, 1'b0, 0, 5, 5);
    drive(1'b0, 0, 32'd0, 1'b0, 0, 5, 5);

    drive(1'b1, 0, 32'hDEADBEEF, 1'b1, 0, 0, 0);
    drive(1'b0, 0, 32'd0, 1'b0, 0, 0, 0);

    drive(1'b0, 0, 32'd0, 1'b1, 7, 7, 7);
    drive(1'b1, 7, 32'h1234, 1'b0, 0, 7, 7);
    drive(1'b0, 0, 32'd0, 1'b0, 0, 7, 7);

    drive(1'b1, 9, 32'd44, 1'b1, 9, 9, 9);
    drive(1'b0, 0, 32'd0, 1'b0, 0, 9, 9);
    drive(1'b1, 9, 32'd55, 1'b1, 3, 9, 3);
    drive(1'b0, 0, 32'd0, 1'b0, 0, 3, 9);

    drive(1'b1, 4, 32'd8, 1'b0, 0, 4, 4);
    drive(1'b0, 0, 32'd0, 1'b1, 4, 4, 4);
    async_reset(4);
    drive(1'b0, 0, 32'd0, 1'b0, 0, 4, 4);

    // Fill the scoreboard to its ceiling, then drain it.
    for (int i = 0; i < 32; i++) drive(1'b0, 0, 32'd0, 1'b1, i, i, 31 - i);
    check_eq("cnt_full", 64'(bus.pend_cnt), 64'd31);
    for (int i = 0; i < 32; i++) drive(1'b1, i, 32'(i * 3), 1'b0, 0, i, 31 - i);

    for (int n = 0; n < 400; n++) begin
      if (n % 97 == 96) begin
        async_reset(int'($urandom_range(0, 31)));
      end else begin
        drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom(),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
